// File: rtl/l1d_pkg.sv
// Shared definitions for the l1d_cache block: bus widths, FSM state encoding
// and helpers that derive array geometry from the index width.
package l1d_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_FILL   = 2'd2,
    S_WSYNC  = 2'd3
  } state_e;

  function automatic int tag_w(input int idx_bits);
    return ADDR_W - idx_bits;
  endfunction

  function automatic int line_cnt(input int idx_bits);
    return 32'sd1 << idx_bits;
  endfunction

endpackage

// File: rtl/l1d_store.sv
// Tag/valid/data storage for l1d_cache: combinational index read, one write
// port, and a synchronous clear that drops every valid bit.
module l1d_store
  import l1d_pkg::*;
#(
  parameter int IDX_BITS = 7,
  parameter int TAG_W    = 17
) (
  input  logic                clk,
  input  logic                clr_i,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_valid_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic [DATA_W-1:0]   rd_data_o,
  input  logic                wr_en_i,
  input  logic [IDX_BITS-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]    wr_tag_i,
  input  logic [DATA_W-1:0]   wr_data_i
);

  localparam int LINES = line_cnt(IDX_BITS);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_arr_q  [LINES];
  logic [DATA_W-1:0] data_arr_q [LINES];

  // Valid bits are the only reset state; clear wins over a same-cycle install.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      valid_q <= {LINES{1'b0}};
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_arr_q[wr_idx_i]  <= wr_tag_i;
      data_arr_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_arr_q[rd_idx_i];
  assign rd_data_o  = data_arr_q[rd_idx_i];

endmodule

// File: rtl/l1d_cache.sv
// Direct-mapped write-through L1 data cache, one 32-bit word per line.
// Define L1D_STATS_EN to add saturating read hit/miss counters.
module l1d_cache
  import l1d_pkg::*;
#(
  parameter int IDX_BITS = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] bus_l1d_addr,
  input  logic              bus_l1d_start,
  input  logic [DATA_W-1:0] bus_l1d_data,
  input  logic              bus_l1d_we,
  output logic [DATA_W-1:0] bus_l1d_q,
  output logic              bus_l1d_done,
  output logic              bus_l1d_ready,
  output logic [ADDR_W-1:0] sdc_addr,
  output logic [DATA_W-1:0] sdc_data,
  output logic              sdc_we,
  output logic              sdc_start,
  input  logic [DATA_W-1:0] sdc_q,
  input  logic              sdc_done
`ifdef L1D_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W = tag_w(IDX_BITS);

  state_e            state_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_data_q;
  logic              req_we_q;
  logic [DATA_W-1:0] q_q;
  logic              done_q;
  logic              ready_q;
  logic [ADDR_W-1:0] sdc_addr_q;
  logic [DATA_W-1:0] sdc_data_q;
  logic              sdc_we_q;
  logic              sdc_start_q;

  logic [IDX_BITS-1:0] req_idx_s;
  logic [TAG_W-1:0]    req_tag_s;
  logic                rd_valid_s;
  logic [TAG_W-1:0]    rd_tag_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic                hit_s;
  logic                wr_en_s;
  logic [DATA_W-1:0]   wr_data_s;

  assign req_idx_s = req_addr_q[IDX_BITS-1:0];
  assign req_tag_s = req_addr_q[ADDR_W-1:IDX_BITS];
  assign hit_s     = rd_valid_s && (rd_tag_s == req_tag_s);

  // Writes allocate in LOOKUP; read misses install when SDRAM returns the word.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_data_s = req_data_q;
    if (reset) begin
      wr_en_s = 1'b0;
    end else if (state_q == S_LOOKUP && req_we_q) begin
      wr_en_s = 1'b1;
    end else if (state_q == S_FILL && sdc_done) begin
      wr_en_s   = 1'b1;
      wr_data_s = sdc_q;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  l1d_store #(
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W)
  ) u_store (
    .clk        (clk),
    .clr_i      (reset),
    .rd_idx_i   (req_idx_s),
    .rd_valid_o (rd_valid_s),
    .rd_tag_o   (rd_tag_s),
    .rd_data_o  (rd_data_s),
    .wr_en_i    (wr_en_s),
    .wr_idx_i   (req_idx_s),
    .wr_tag_i   (req_tag_s),
    .wr_data_i  (wr_data_s)
  );

  // Request FSM; every handshake output is a register driven from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_addr_q  <= {ADDR_W{1'b0}};
      req_data_q  <= {DATA_W{1'b0}};
      req_we_q    <= 1'b0;
      q_q         <= {DATA_W{1'b0}};
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
      sdc_addr_q  <= {ADDR_W{1'b0}};
      sdc_data_q  <= {DATA_W{1'b0}};
      sdc_we_q    <= 1'b0;
      sdc_start_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      sdc_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus_l1d_start) begin
            req_addr_q <= bus_l1d_addr;
            req_data_q <= bus_l1d_data;
            req_we_q   <= bus_l1d_we;
            ready_q    <= 1'b0;
            state_q    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (req_we_q) begin
            sdc_start_q <= 1'b1;
            sdc_we_q    <= 1'b1;
            sdc_addr_q  <= req_addr_q;
            sdc_data_q  <= req_data_q;
            state_q     <= S_WSYNC;
          end else if (hit_s) begin
            q_q     <= rd_data_s;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            sdc_start_q <= 1'b1;
            sdc_we_q    <= 1'b0;
            sdc_addr_q  <= req_addr_q;
            state_q     <= S_FILL;
          end
        end
        S_FILL: begin
          if (sdc_done) begin
            q_q     <= sdc_q;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_WSYNC: begin
          if (sdc_done) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_l1d_q     = q_q;
  assign bus_l1d_done  = done_q;
  assign bus_l1d_ready = ready_q;
  assign sdc_addr      = sdc_addr_q;
  assign sdc_data      = sdc_data_q;
  assign sdc_we        = sdc_we_q;
  assign sdc_start     = sdc_start_q;

`ifdef L1D_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic [31:0] hit_cnt_d;
  logic [31:0] miss_cnt_d;

  // Read lookups only; counters stick at all-ones instead of wrapping.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_LOOKUP && !req_we_q) begin
      if (hit_s) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) begin
          hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
          hit_cnt_d = hit_cnt_q;
        end
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) begin
          miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
          miss_cnt_d = miss_cnt_q;
        end
      end
    end else begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1d_cache.sv
// Scoreboard bench for l1d_cache: directed transactions push expected bus and
// SDRAM responses; monitors pop and compare as the DUT produces them.
module tb_l1d_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] bus_l1d_addr;
  logic        bus_l1d_start;
  logic [31:0] bus_l1d_data;
  logic        bus_l1d_we;
  logic [31:0] bus_l1d_q;
  logic        bus_l1d_done;
  logic        bus_l1d_ready;
  logic [23:0] sdc_addr;
  logic [31:0] sdc_data;
  logic        sdc_we;
  logic        sdc_start;
  logic [31:0] sdc_q;
  logic        sdc_done;
`ifdef L1D_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk = ~clk;

  l1d_cache #(.IDX_BITS(7)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_l1d_addr  (bus_l1d_addr),
    .bus_l1d_start (bus_l1d_start),
    .bus_l1d_data  (bus_l1d_data),
    .bus_l1d_we    (bus_l1d_we),
    .bus_l1d_q     (bus_l1d_q),
    .bus_l1d_done  (bus_l1d_done),
    .bus_l1d_ready (bus_l1d_ready),
    .sdc_addr      (sdc_addr),
    .sdc_data      (sdc_data),
    .sdc_we        (sdc_we),
    .sdc_start     (sdc_start),
    .sdc_q         (sdc_q),
    .sdc_done      (sdc_done)
`ifdef L1D_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  typedef struct {
    logic [31:0] q;
    int          lat;
    int          t0;
  } bexp_t;

  typedef struct {
    logic [23:0] a;
    logic        we;
    logic [31:0] d;
  } sexp_t;

  bexp_t       bq[$];
  sexp_t       sq[$];
  logic [31:0] mem [logic [23:0]];
  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic [31:0] resp_val(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return {8'h00, a} ^ 32'hA5A5_A5A5;
  endfunction

  // Bus monitor: every done must match the oldest expected response.
  initial begin
    forever begin
      bexp_t e;
      @(negedge clk);
      if (bus_l1d_done === 1'b1) begin
        n_done++;
        if (bq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = bq.pop_front();
          check("bus_q", bus_l1d_q, e.q);
          check("done_latency", cyc - e.t0, e.lat);
          check("ready_at_done", {31'd0, bus_l1d_ready}, 32'd1);
        end
      end
    end
  end

  // SDRAM request monitor: each start pulse must match the oldest expected request.
  initial begin
    forever begin
      sexp_t s;
      @(negedge clk);
      if (sdc_start === 1'b1) begin
        if (sq.size() == 0) begin
          check("unexpected_sdc_start", 32'd1, 32'd0);
        end else begin
          s = sq.pop_front();
          check("sdc_addr", {8'd0, sdc_addr}, {8'd0, s.a});
          check("sdc_we", {31'd0, sdc_we}, {31'd0, s.we});
          if (s.we) check("sdc_data", sdc_data, s.d);
        end
      end
    end
  end

  // SDRAM model: answers five cycles after each request.
  initial begin
    logic [23:0] a;
    logic [31:0] d;
    logic        w;
    sdc_done = 1'b0;
    sdc_q    = 32'd0;
    forever begin
      @(negedge clk);
      if (sdc_start === 1'b1) begin
        a = sdc_addr;
        d = sdc_data;
        w = sdc_we;
        repeat (5) @(negedge clk);
        if (w) mem[a] = d;
        sdc_q    = w ? 32'd0 : resp_val(a);
        sdc_done = 1'b1;
        @(negedge clk);
        sdc_done = 1'b0;
      end
    end
  end

  task automatic start_txn(input logic [23:0] a, input logic w, input logic [31:0] d,
                           input bit hit, input logic [31:0] expq, input bit expect_done);
    int    t;
    bexp_t e;
    sexp_t s;
    t = 0;
    while (bus_l1d_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (bus_l1d_ready !== 1'b1) check("timeout_ready", 32'd1, 32'd0);
    if (expect_done) begin
      e.q   = expq;
      e.lat = hit ? 2 : 8;
      e.t0  = cyc;
      bq.push_back(e);
    end
    if (!hit) begin
      s.a  = a;
      s.we = w;
      s.d  = d;
      sq.push_back(s);
    end
    bus_l1d_addr  = a;
    bus_l1d_we    = w;
    bus_l1d_data  = d;
    bus_l1d_start = 1'b1;
    @(negedge clk);
    bus_l1d_start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (n_done == d0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (n_done == d0) check("timeout_done", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic txn(input logic [23:0] a, input logic w, input logic [31:0] d,
                     input bit hit, input logic [31:0] expq);
    int d0;
    d0 = n_done;
    start_txn(a, w, d, hit, expq, 1'b1);
    wait_done(d0);
  endtask

  task automatic wait_sdc_start();
    int t;
    t = 0;
    while (sdc_start !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sdc_start !== 1'b1) check("timeout_sdc_start", 32'd1, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got 0x00000001 expected 0x00000000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    mem[24'h000010] = 32'hDEAD_BEEF;
    mem[24'h000090] = 32'hCAFE_F00D;
    mem[24'h000030] = 32'h55AA_55AA;
    reset         = 1'b1;
    bus_l1d_addr  = 24'd0;
    bus_l1d_start = 1'b0;
    bus_l1d_data  = 32'd0;
    bus_l1d_we    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_q", bus_l1d_q, 32'd0);
    check("rst_done", {31'd0, bus_l1d_done}, 32'd0);
    check("rst_ready", {31'd0, bus_l1d_ready}, 32'd1);
    check("rst_sdc_start", {31'd0, sdc_start}, 32'd0);
    check("rst_sdc_we", {31'd0, sdc_we}, 32'd0);
    check("rst_sdc_addr", {8'd0, sdc_addr}, 32'd0);
    check("rst_sdc_data", sdc_data, 32'd0);
`ifdef L1D_STATS_EN
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif

    txn(24'h000010, 1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF);          // miss
    txn(24'h000010, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);          // hit
    txn(24'h000090, 1'b0, 32'd0, 1'b0, 32'hCAFE_F00D);          // conflict
    txn(24'h000010, 1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF);          // evicted
    txn(24'h000020, 1'b1, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF);  // write keeps q
    txn(24'h000020, 1'b0, 32'd0, 1'b1, 32'h1234_5678);          // write-allocated

    // A start while busy must be ignored.
    d0 = n_done;
    start_txn(24'h000030, 1'b0, 32'd0, 1'b0, 32'h55AA_55AA, 1'b1);
    wait_sdc_start();
    @(negedge clk);
    check("busy_ready", {31'd0, bus_l1d_ready}, 32'd0);
    bus_l1d_addr  = 24'h000040;
    bus_l1d_we    = 1'b1;
    bus_l1d_data  = 32'hFFFF_0000;
    bus_l1d_start = 1'b1;
    @(negedge clk);
    bus_l1d_start = 1'b0;
    check("busy_ready_after", {31'd0, bus_l1d_ready}, 32'd0);
    wait_done(d0);
    repeat (3) @(negedge clk);
    check("busy_single_done", n_done - d0, 32'd1);

    txn(24'h000030, 1'b0, 32'd0, 1'b1, 32'h55AA_55AA);
    txn(24'h000040, 1'b0, 32'd0, 1'b0, 32'hA5A5_A5E5);          // ignored write left no line
    txn(24'hFFFFFF, 1'b0, 32'd0, 1'b0, 32'hA55A_5A5A);          // max tag, idx 0x7F
    txn(24'h00007F, 1'b0, 32'd0, 1'b0, 32'hA5A5_A5DA);
    txn(24'hFFFFFF, 1'b0, 32'd0, 1'b0, 32'hA55A_5A5A);
`ifdef L1D_STATS_EN
    check("hit_count", hit_count, 32'd3);
    check("miss_count", miss_count, 32'd8);
`endif

    // Reset two cycles after the SDRAM request; its late done must be dropped.
    start_txn(24'h000110, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    wait_sdc_start();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_ready", {31'd0, bus_l1d_ready}, 32'd1);
    check("post_rst_q", bus_l1d_q, 32'd0);
    check("post_rst_sdc_addr", {8'd0, sdc_addr}, 32'd0);
`ifdef L1D_STATS_EN
    check("post_rst_hit_count", hit_count, 32'd0);
    check("post_rst_miss_count", miss_count, 32'd0);
`endif
    txn(24'h000010, 1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF);          // valid was cleared

    repeat (5) @(negedge clk);
    check("bus_queue_empty", bq.size(), 32'd0);
    check("sdc_queue_empty", sq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
